// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note record/playback sequencer.
// A buffer entry packs {note[3:0], octave[1:0]}.
package note_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      NOTE,
      GAP,
      DONE
   } state_t;

   localparam logic [3:0] REST_THRESHOLD = 4'd12;
   localparam int         ENTRY_W        = 6;

   // Note codes 12..15 are rests: they take up time but stay silent.
   function automatic logic is_tone(input logic [3:0] note);
      return note < REST_THRESHOLD;
   endfunction

endpackage

// File: rtl/note_sequencer_timer.sv
// Loadable down-counter; tc marks the last cycle of a loaded duration.
// A load takes priority over counting, and the counter parks at zero.
module seq_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/note_sequencer.sv
// Records keyboard note/octave events into a small buffer and replays them,
// holding each note for NOTE_CYCLES followed by a silent GAP_CYCLES.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int NOTE_CYCLES = 12500000,
   parameter int GAP_CYCLES  = 1250000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rec_valid,
   input  logic [3:0]               rec_note,
   input  logic [1:0]               rec_octave,
   input  logic                     play_req,
   input  logic                     stop_req,
   input  logic                     clear_req,
   output logic [3:0]               note_out,
   output logic [1:0]               octave_out,
   output logic                     sound_en,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic [$clog2(DEPTH)-1:0] play_index
);

   localparam int AW      = $clog2(DEPTH);
   localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   state_t         state_q, state_d;
   logic [AW:0]    count_q, count_d;
   logic [AW-1:0]  index_q, index_d;
   logic [3:0]     note_q, note_d;
   logic [1:0]     octave_q, octave_d;
   logic           sound_en_q, sound_en_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           wr_en;
   logic           timer_load;
   logic [TW-1:0]  timer_value;
   logic           timer_tc;
   logic           full_w;

   assign full_w = (count_q == (AW + 1)'(DEPTH));

   seq_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .tc         (timer_tc)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      index_d     = index_q;
      note_d      = note_q;
      octave_d    = octave_q;
      wr_en       = 1'b0;
      timer_load  = 1'b0;
      timer_value = '0;

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               count_d = '0;
            end else if (play_req) begin
               if (count_q != '0) begin
                  index_d = '0;
                  state_d = LOAD;
               end
            end else if (rec_valid && !full_w) begin
               wr_en   = 1'b1;
               count_d = count_q + (AW + 1)'(1);
            end
         end
         LOAD: begin
            {note_d, octave_d} = mem_q[index_q];
            timer_load         = 1'b1;
            timer_value        = TW'(NOTE_CYCLES);
            state_d            = NOTE;
         end
         NOTE: begin
            if (timer_tc) begin
               timer_load  = 1'b1;
               timer_value = TW'(GAP_CYCLES);
               state_d     = GAP;
            end
         end
         GAP: begin
            if (timer_tc) begin
               if ({1'b0, index_q} == count_q - (AW + 1)'(1)) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + AW'(1);
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over every in-flight transition; count and buffer survive.
      if (state_q != IDLE && stop_req) begin
         state_d = IDLE;
      end

      sound_en_d = (state_d == NOTE) && is_tone(note_d);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         index_q    <= '0;
         note_q     <= '0;
         octave_q   <= '0;
         sound_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         index_q    <= index_d;
         note_q     <= note_d;
         octave_q   <= octave_d;
         sound_en_q <= sound_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Buffer storage has no reset; count alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[count_q[AW-1:0]] <= {rec_note, rec_octave};
      end
   end

   assign note_out   = note_q;
   assign octave_out = octave_q;
   assign sound_en   = sound_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign count      = count_q;
   assign full       = full_w;
   assign play_index = index_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a small buffer model and a
// scoreboard queue of expected playback entries.
module tb_note_sequencer;

   localparam int DEPTH = 4;
   localparam int NC    = 4;
   localparam int GC    = 2;
   localparam int P     = 1 + NC + GC;

   logic       clk;
   logic       reset;
   logic       rec_valid;
   logic [3:0] rec_note;
   logic [1:0] rec_octave;
   logic       play_req;
   logic       stop_req;
   logic       clear_req;
   logic [3:0] note_out;
   logic [1:0] octave_out;
   logic       sound_en;
   logic       busy;
   logic       done;
   logic [2:0] count;
   logic       full;
   logic [1:0] play_index;

   int testsRun;
   int testsFailed;

   logic [5:0] modelMem [DEPTH];
   int         modelCount;
   logic [5:0] expQ [$];

   note_sequencer #(
      .DEPTH      (DEPTH),
      .NOTE_CYCLES(NC),
      .GAP_CYCLES (GC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rec_valid  (rec_valid),
      .rec_note   (rec_note),
      .rec_octave (rec_octave),
      .play_req   (play_req),
      .stop_req   (stop_req),
      .clear_req  (clear_req),
      .note_out   (note_out),
      .octave_out (octave_out),
      .sound_en   (sound_en),
      .busy       (busy),
      .done       (done),
      .count      (count),
      .full       (full),
      .play_index (play_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkIdleOutputsZero(input string tag);
      checkOutput({tag, "_note"}, note_out, 0);
      checkOutput({tag, "_oct"}, octave_out, 0);
      checkOutput({tag, "_snd"}, sound_en, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_count"}, count, 0);
      checkOutput({tag, "_full"}, full, 0);
      checkOutput({tag, "_idx"}, play_index, 0);
   endtask

   // Record one note; the model drops it when the buffer is already full.
   task automatic applyStimulus(input logic [3:0] n, input logic [1:0] o);
      rec_valid  = 1'b1;
      rec_note   = n;
      rec_octave = o;
      tick();
      rec_valid = 1'b0;
      if (modelCount < DEPTH) begin
         modelMem[modelCount] = {n, o};
         modelCount++;
      end
      checkOutput("rec_count", count, modelCount);
      checkOutput("rec_full", full, modelCount == DEPTH);
   endtask

   task automatic applyClear(input bit withRec);
      clear_req  = 1'b1;
      rec_valid  = withRec;
      rec_note   = 4'd2;
      rec_octave = 2'd1;
      tick();
      clear_req  = 1'b0;
      rec_valid  = 1'b0;
      modelCount = 0;
      checkOutput("clear_count", count, 0);
   endtask

   // Starts playback and walks it cycle by cycle against the expected schedule.
   // stopAt/resetAt/pokeAt name a cycle offset from play_req (0 = unused).
   task automatic playAndCheck(input int stopAt, input int resetAt, input int pokeAt,
                               input bit withRec);
      int n;
      int k;
      int ph;
      int last;
      logic [5:0] cur;
      n   = modelCount;
      cur = '0;
      for (int i = 0; i < n; i++) expQ.push_back(modelMem[i]);
      play_req = 1'b1;
      if (withRec) begin
         rec_valid  = 1'b1;
         rec_note   = 4'd7;
         rec_octave = 2'd3;
      end
      tick();
      play_req  = 1'b0;
      rec_valid = 1'b0;
      if (n == 0) begin
         for (int c = 0; c < 10; c++) begin
            checkOutput("empty_busy", busy, 0);
            checkOutput("empty_done", done, 0);
            tick();
         end
         return;
      end
      last = 2 + n * P;
      for (int c = 1; c <= last; c++) begin
         k  = (c - 1) / P;
         ph = (c - 1) % P;
         if (c <= n * P) begin
            checkOutput("play_busy", busy, 1);
            checkOutput("play_done", done, 0);
            if (ph == 0) begin
               checkOutput("load_snd", sound_en, 0);
            end else if (ph == 1) begin
               cur = expQ.pop_front();
               checkOutput("note", note_out, cur[5:2]);
               checkOutput("octave", octave_out, cur[1:0]);
               checkOutput("index", play_index, k);
               checkOutput("note_snd", sound_en, cur[5:2] < 4'd12);
            end else if (ph <= NC) begin
               checkOutput("note_snd", sound_en, cur[5:2] < 4'd12);
            end else begin
               checkOutput("gap_snd", sound_en, 0);
               checkOutput("gap_note", note_out, cur[5:2]);
            end
         end else if (c == n * P + 1) begin
            checkOutput("done_pulse", done, 1);
            checkOutput("done_busy", busy, 1);
            checkOutput("done_snd", sound_en, 0);
         end else begin
            checkOutput("end_busy", busy, 0);
            checkOutput("end_done", done, 0);
            checkOutput("end_count", count, modelCount);
            checkOutput("end_idx", play_index, n - 1);
         end

         if (c == stopAt) begin
            stop_req = 1'b1;
            tick();
            stop_req = 1'b0;
            checkOutput("stop_busy", busy, 0);
            checkOutput("stop_snd", sound_en, 0);
            checkOutput("stop_count", count, modelCount);
            for (int j = 0; j < 2 * P; j++) begin
               checkOutput("stop_done", done, 0);
               tick();
            end
            expQ.delete();
            return;
         end
         if (c == resetAt) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            checkIdleOutputsZero("midrst");
            modelCount = 0;
            expQ.delete();
            return;
         end
         if (c == pokeAt) begin
            rec_valid  = 1'b1;
            clear_req  = 1'b1;
            rec_note   = 4'd1;
            rec_octave = 2'd2;
         end
         tick();
         rec_valid = 1'b0;
         clear_req = 1'b0;
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      modelCount  = 0;
      reset       = 1'b1;
      rec_valid   = 1'b0;
      rec_note    = '0;
      rec_octave  = '0;
      play_req    = 1'b0;
      stop_req    = 1'b0;
      clear_req   = 1'b0;
      tick();
      tick();
      checkIdleOutputsZero("reset");
      reset = 1'b0;
      tick();

      playAndCheck(0, 0, 0, 1'b0);

      applyStimulus(4'd5, 2'd1);
      applyStimulus(4'd13, 2'd0);
      applyStimulus(4'd9, 2'd2);
      playAndCheck(0, 0, 0, 1'b0);

      playAndCheck(10, 0, 0, 1'b0);
      playAndCheck(0, 0, 0, 1'b0);

      playAndCheck(0, 0, 3, 1'b0);

      applyClear(1'b1);
      tick();
      checkOutput("clear_rec_count", count, 0);

      applyStimulus(4'd0, 2'd3);
      applyStimulus(4'd11, 2'd1);
      playAndCheck(0, 0, 0, 1'b1);

      applyClear(1'b0);
      applyStimulus(4'd1, 2'd0);
      applyStimulus(4'd2, 2'd1);
      applyStimulus(4'd15, 2'd2);
      applyStimulus(4'd4, 2'd3);
      applyStimulus(4'd6, 2'd0);
      playAndCheck(0, 0, 0, 1'b0);

      playAndCheck(0, 6, 0, 1'b0);
      applyStimulus(4'd3, 2'd3);
      playAndCheck(0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
